// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg : ID/EX pipeline register for the RV32I core.
//   Captures PC, instruction, register addresses, regfile operands and the
//   sign-extended immediate. Supports stall hold with WB refresh of held
//   operands, flush, and single-bubble load-use insertion.
// Optional feature macro: WB_BYPASS_EN -- forward a same-cycle WB write into
//   the captured operands (regfile write-then-read).
// Ports:
//   clk, i_rst_n (sync, active-low)
//   i_valid / o_ready        : IF/ID handshake (o_ready is combinational)
//   i_stall, i_flush         : EX busy hold / branch kill
//   i_pc, i_instr, i_rs1_data, i_rs2_data : IF/ID payload and regfile reads
//   i_wb_wen, i_wb_waddr, i_wb_wdata      : writeback port
//   o_valid, o_pc, o_instr, o_rs1_addr, o_rs2_addr, o_rd_addr,
//   o_rs1_data, o_rs2_data, o_imm         : registered EX payload
// ---------------------------------------------------------------------------
module id_ex_reg #(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_pc,
   input  logic [DATA_WIDTH-1:0] i_instr,
   input  logic [DATA_WIDTH-1:0] i_rs1_data,
   input  logic [DATA_WIDTH-1:0] i_rs2_data,
   input  logic                  i_wb_wen,
   input  logic [4:0]            i_wb_waddr,
   input  logic [DATA_WIDTH-1:0] i_wb_wdata,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_pc,
   output logic [DATA_WIDTH-1:0] o_instr,
   output logic [4:0]            o_rs1_addr,
   output logic [4:0]            o_rs2_addr,
   output logic [4:0]            o_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rs1_data,
   output logic [DATA_WIDTH-1:0] o_rs2_data,
   output logic [DATA_WIDTH-1:0] o_imm
);

   localparam int unsigned AW = 5;

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
      logic [AW-1:0]         rs1_addr;
      logic [AW-1:0]         rs2_addr;
      logic [AW-1:0]         rd_addr;
      logic [DATA_WIDTH-1:0] rs1_data;
      logic [DATA_WIDTH-1:0] rs2_data;
      logic [DATA_WIDTH-1:0] imm;
   } ex_t;

   ex_t ex_q, ex_d;
   ex_t bubble_c;

   logic          hazard_c;
   logic [AW-1:0] in_rs1_c, in_rs2_c;
   logic [31:0]   imm32_c;
   logic [DATA_WIDTH-1:0] op1_c, op2_c;

   assign in_rs1_c = i_instr[19:15];
   assign in_rs2_c = i_instr[24:20];

   // Bubble payload: invalid, NOP encoding, everything else zero
   always_comb begin
      bubble_c       = '0;
      bubble_c.instr = NOP_INSTR;
   end

   // Load in EX whose rd feeds the incoming instruction
   assign hazard_c = ex_q.valid && (ex_q.instr[6:0] == 7'b0000011)
                     && (ex_q.rd_addr != AW'(0)) && i_valid
                     && ((ex_q.rd_addr == in_rs1_c) || (ex_q.rd_addr == in_rs2_c));

   assign o_ready = i_flush || (!i_stall && !hazard_c);

   // Immediate decode by opcode
   always_comb begin
      imm32_c = 32'h0;
      unique case (i_instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111:
            imm32_c = {{20{i_instr[31]}}, i_instr[31:20]};
         7'b0100011:
            imm32_c = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         7'b1100011:
            imm32_c = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm32_c = {i_instr[31:12], 12'h000};
         7'b1101111:
            imm32_c = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
         default:
            imm32_c = 32'h0;
      endcase
   end

   // Capture operands: x0 reads as zero; optional same-cycle WB forwarding
   always_comb begin
      op1_c = i_rs1_data;
      op2_c = i_rs2_data;
`ifdef WB_BYPASS_EN
      if (i_wb_wen && (i_wb_waddr != AW'(0)) && (i_wb_waddr == in_rs1_c)) op1_c = i_wb_wdata;
      if (i_wb_wen && (i_wb_waddr != AW'(0)) && (i_wb_waddr == in_rs2_c)) op2_c = i_wb_wdata;
`endif
      if (in_rs1_c == AW'(0)) op1_c = '0;
      if (in_rs2_c == AW'(0)) op2_c = '0;
   end

   // Next-state selection: flush > stall > load-use > capture
   always_comb begin
      ex_d = ex_q;
      if (i_flush) begin
         ex_d = bubble_c;
      end else if (i_stall) begin
         // Keep held operands coherent with writebacks that land while stalled
         if (i_wb_wen && (i_wb_waddr != AW'(0)) && (i_wb_waddr == ex_q.rs1_addr))
            ex_d.rs1_data = i_wb_wdata;
         if (i_wb_wen && (i_wb_waddr != AW'(0)) && (i_wb_waddr == ex_q.rs2_addr))
            ex_d.rs2_data = i_wb_wdata;
      end else if (hazard_c || !i_valid) begin
         ex_d = bubble_c;
      end else begin
         ex_d.valid    = 1'b1;
         ex_d.pc       = i_pc;
         ex_d.instr    = i_instr;
         ex_d.rs1_addr = in_rs1_c;
         ex_d.rs2_addr = in_rs2_c;
         ex_d.rd_addr  = i_instr[11:7];
         ex_d.rs1_data = op1_c;
         ex_d.rs2_data = op2_c;
         ex_d.imm      = DATA_WIDTH'($signed(imm32_c));
      end
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) ex_q <= bubble_c;
      else          ex_q <= ex_d;
   end

   assign o_valid    = ex_q.valid;
   assign o_pc       = ex_q.pc;
   assign o_instr    = ex_q.instr;
   assign o_rs1_addr = ex_q.rs1_addr;
   assign o_rs2_addr = ex_q.rs2_addr;
   assign o_rd_addr  = ex_q.rd_addr;
   assign o_rs1_data = ex_q.rs1_data;
   assign o_rs2_data = ex_q.rs2_data;
   assign o_imm      = ex_q.imm;

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg : directed self-checking bench for id_ex_reg.
//   Inputs are driven 1 time unit after the rising edge; registered outputs
//   and the combinational o_ready are sampled after settling.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic        i_stall;
   logic        i_flush;
   logic [31:0] i_pc, i_instr, i_rs1_data, i_rs2_data;
   logic        i_wb_wen;
   logic [4:0]  i_wb_waddr;
   logic [31:0] i_wb_wdata;
   logic        o_valid;
   logic [31:0] o_pc, o_instr;
   logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
   logic [31:0] o_rs1_data, o_rs2_data, o_imm;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_reg dut (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_stall    (i_stall),
      .i_flush    (i_flush),
      .i_pc       (i_pc),
      .i_instr    (i_instr),
      .i_rs1_data (i_rs1_data),
      .i_rs2_data (i_rs2_data),
      .i_wb_wen   (i_wb_wen),
      .i_wb_waddr (i_wb_waddr),
      .i_wb_wdata (i_wb_wdata),
      .o_valid    (o_valid),
      .o_pc       (o_pc),
      .o_instr    (o_instr),
      .o_rs1_addr (o_rs1_addr),
      .o_rs2_addr (o_rs2_addr),
      .o_rd_addr  (o_rd_addr),
      .o_rs1_data (o_rs1_data),
      .o_rs2_data (o_rs2_data),
      .o_imm      (o_imm)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] r1, input logic [31:0] r2);
      i_valid    = v;
      i_pc       = pc;
      i_instr    = ins;
      i_rs1_data = r1;
      i_rs2_data = r2;
   endtask

   task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
      i_wb_wen   = en;
      i_wb_waddr = a;
      i_wb_wdata = d;
   endtask

   logic [31:0] exp_byp;

   initial begin
      // Reset with random inputs
      i_rst_n = 1'b0;
      i_stall = 1'b0;
      i_flush = 1'b0;
      drive(1'b1, $urandom, $urandom, $urandom, $urandom);
      wb(1'b1, 5'($urandom), $urandom);
      tick();
      drive(1'b1, $urandom, $urandom, $urandom, $urandom);
      tick();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_instr", o_instr, 32'h13);
      chk("rst_rs1_data", o_rs1_data, 32'd0);
      chk("rst_imm", o_imm, 32'd0);
      chk("rst_pc", o_pc, 32'd0);

      // Capture addi x5,x1,-4
      i_rst_n = 1'b1;
      wb(1'b0, 5'd0, 32'd0);
      drive(1'b1, 32'h100, 32'hFFC08293, 32'd7, 32'h1234);
      #1;
      chk("cap_ready", 32'(o_ready), 32'd1);
      tick();
      chk("cap_valid", 32'(o_valid), 32'd1);
      chk("cap_rd", 32'(o_rd_addr), 32'd5);
      chk("cap_rs1_addr", 32'(o_rs1_addr), 32'd1);
      chk("cap_rs2_addr", 32'(o_rs2_addr), 32'd28);
      chk("cap_rs1_data", o_rs1_data, 32'd7);
      chk("cap_rs2_data", o_rs2_data, 32'h1234);
      chk("cap_imm", o_imm, 32'hFFFFFFFC);
      chk("cap_pc", o_pc, 32'h100);

      // Load-use: lw x5,0(x2) then add x6,x5,x3
      drive(1'b1, 32'h104, 32'h00012283, 32'h40, 32'h0);
      tick();
      chk("lw_instr", o_instr, 32'h00012283);
      chk("lw_rd", 32'(o_rd_addr), 32'd5);
      drive(1'b1, 32'h108, 32'h00328333, 32'h11, 32'h22);
      #1;
      chk("lu_ready_low", 32'(o_ready), 32'd0);
      tick();
      chk("lu_bubble_valid", 32'(o_valid), 32'd0);
      chk("lu_bubble_instr", o_instr, 32'h13);
      chk("lu_bubble_pc", o_pc, 32'd0);
      chk("lu_ready_high", 32'(o_ready), 32'd1);
      tick();
      chk("lu_add_valid", 32'(o_valid), 32'd1);
      chk("lu_add_instr", o_instr, 32'h00328333);
      chk("lu_add_rs1", o_rs1_data, 32'h11);
      chk("lu_add_rs2", o_rs2_data, 32'h22);
      chk("lu_add_imm", o_imm, 32'd0);

      // Stall + refresh: addi x7,x4,5 held, WB writes x4
      drive(1'b1, 32'h10C, 32'h00520393, 32'd1, 32'h99);
      tick();
      chk("st_cap_rs1", o_rs1_data, 32'd1);
      chk("st_cap_imm", o_imm, 32'd5);
      i_stall = 1'b1;
      drive(1'b1, 32'h200, 32'hFFC08293, 32'h5, 32'h6);
      wb(1'b1, 5'd4, 32'hAA);
      #1;
      chk("st_ready", 32'(o_ready), 32'd0);
      tick();
      chk("st_ref_rs1", o_rs1_data, 32'hAA);
      chk("st_ref_rs2_held", o_rs2_data, 32'h99);
      chk("st_pc_held", o_pc, 32'h10C);
      chk("st_instr_held", o_instr, 32'h00520393);
      wb(1'b1, 5'd0, 32'hBB);
      tick();
      chk("st_wb_x0", o_rs1_data, 32'hAA);
      wb(1'b1, 5'd5, 32'hCC);
      tick();
      chk("st_ref_rs2", o_rs2_data, 32'hCC);
      chk("st_rs1_indep", o_rs1_data, 32'hAA);
      wb(1'b0, 5'd4, 32'hEE);
      tick();
      chk("st_wen_off", o_rs1_data, 32'hAA);

      // Flush during stall
      i_flush = 1'b1;
      #1;
      chk("fl_ready", 32'(o_ready), 32'd1);
      tick();
      chk("fl_valid", 32'(o_valid), 32'd0);
      chk("fl_instr", o_instr, 32'h13);
      chk("fl_rs1", o_rs1_data, 32'd0);
      chk("fl_pc", o_pc, 32'd0);
      i_flush = 1'b0;
      i_stall = 1'b0;

      // x0 operand forced to zero: addi x1,x0,-1
      drive(1'b1, 32'h300, 32'hFFF00093, 32'hDEAD, 32'h77);
      tick();
      chk("x0_rs1_data", o_rs1_data, 32'd0);
      chk("x0_rs2_data", o_rs2_data, 32'h77);
      chk("x0_imm", o_imm, 32'hFFFFFFFF);

      // U-type and B-type immediates
      drive(1'b1, 32'h304, 32'h12345437, 32'h0, 32'h0);
      tick();
      chk("u_imm", o_imm, 32'h12345000);
      chk("u_rd", 32'(o_rd_addr), 32'd8);
      drive(1'b1, 32'h308, 32'hFE000EE3, 32'h0, 32'h0);
      tick();
      chk("b_imm", o_imm, 32'hFFFFFFFC);

      // Same-cycle WB to rs2 (x9): add x1,x8,x9
`ifdef WB_BYPASS_EN
      exp_byp = 32'h55;
`else
      exp_byp = 32'd3;
`endif
      drive(1'b1, 32'h30C, 32'h009400B3, 32'h77, 32'd3);
      wb(1'b1, 5'd9, 32'h55);
      tick();
      chk("byp_rs2", o_rs2_data, exp_byp);
      chk("byp_rs1", o_rs1_data, 32'h77);
      wb(1'b0, 5'd0, 32'd0);

      // No valid instruction -> bubble
      drive(1'b0, 32'h310, 32'h00520393, 32'd1, 32'd2);
      tick();
      chk("idle_valid", 32'(o_valid), 32'd0);
      chk("idle_instr", o_instr, 32'h13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
